// File: rtl/uart_cmd_parser.sv
`default_nettype none
// ==========================================================================
// uart_cmd_parser : ASCII "Waadd<EOL>" / "Raa<EOL>" command parser with timeout
// Revision 1.0
// ==========================================================================
module uart_cmd_parser #(
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic       cmd_valid,
   output logic       cmd_write,
   output logic [7:0] cmd_addr,
   output logic [7:0] cmd_wdata,
   output logic       cmd_err,
   output logic [1:0] err_code,
   output logic       busy
);

   localparam int               c_CNT_W   = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [c_CNT_W-1:0] c_TIMEOUT = c_CNT_W'(TIMEOUT_CYCLES);
   localparam logic [1:0]       c_ERR_CHAR = 2'b01;
   localparam logic [1:0]       c_ERR_TMO  = 2'b10;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ADDR_HI = 3'd1,
      ADDR_LO = 3'd2,
      DATA_HI = 3'd3,
      DATA_LO = 3'd4,
      EOL     = 3'd5,
      FLUSH   = 3'd6
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [c_CNT_W-1:0]   r_cnt;
   logic                 r_is_write;
   logic [3:0]           r_nib_ahi;
   logic [3:0]           r_nib_alo;
   logic [3:0]           r_nib_dhi;
   logic [3:0]           r_nib_dlo;

   logic                 r_cmd_valid;
   logic                 r_cmd_write;
   logic [7:0]           r_cmd_addr;
   logic [7:0]           r_cmd_wdata;
   logic                 r_cmd_err;
   logic [1:0]           r_err_code;

   logic                 w_is_term;
   logic                 w_is_blank;
   logic                 w_is_wr;
   logic                 w_is_rd;
   logic                 w_is_hex;
   logic [3:0]           w_hex_val;
   logic                 w_timeout;
   logic                 w_ld_valid;
   logic                 w_ld_err;
   logic [1:0]           w_err_code;
   logic                 w_ld_op;
   logic                 w_ld_nib;

   // Byte classification
   assign w_is_term  = (rx_data == 8'h0D) || (rx_data == 8'h0A);
   assign w_is_blank = w_is_term || (rx_data == 8'h20);
   assign w_is_wr    = (rx_data == 8'h57) || (rx_data == 8'h77);
   assign w_is_rd    = (rx_data == 8'h52) || (rx_data == 8'h72);

   always_comb begin
      w_is_hex  = 1'b1;
      w_hex_val = 4'h0;
      if ((rx_data >= 8'h30) && (rx_data <= 8'h39)) begin
         w_hex_val = rx_data[3:0];
      end else if (((rx_data >= 8'h41) && (rx_data <= 8'h46)) ||
                   ((rx_data >= 8'h61) && (rx_data <= 8'h66))) begin
         w_hex_val = rx_data[3:0] + 4'd9;
      end else begin
         w_is_hex = 1'b0;
      end
   end

   // The counter is held at zero in IDLE, so it can only expire mid-frame.
   assign w_timeout = (r_state != IDLE) && (r_cnt == c_TIMEOUT);

   always_comb begin
      w_state_nxt = r_state;
      w_ld_valid  = 1'b0;
      w_ld_err    = 1'b0;
      w_err_code  = c_ERR_CHAR;
      w_ld_op     = 1'b0;
      w_ld_nib    = 1'b0;
      if (rx_valid) begin
         case (r_state)
            IDLE: begin
               if (w_is_wr || w_is_rd) begin
                  w_ld_op     = 1'b1;
                  w_state_nxt = ADDR_HI;
               end else if (!w_is_blank) begin
                  w_ld_err    = 1'b1;
                  w_state_nxt = FLUSH;
               end
            end
            ADDR_HI, ADDR_LO, DATA_HI, DATA_LO: begin
               if (w_is_hex) begin
                  w_ld_nib = 1'b1;
                  if (r_state == ADDR_HI) begin
                     w_state_nxt = ADDR_LO;
                  end else if (r_state == ADDR_LO) begin
                     w_state_nxt = r_is_write ? DATA_HI : EOL;
                  end else if (r_state == DATA_HI) begin
                     w_state_nxt = DATA_LO;
                  end else begin
                     w_state_nxt = EOL;
                  end
               end else begin
                  w_ld_err    = 1'b1;
                  w_state_nxt = w_is_term ? IDLE : FLUSH;
               end
            end
            EOL: begin
               if (w_is_term) begin
                  w_ld_valid  = 1'b1;
                  w_state_nxt = IDLE;
               end else begin
                  w_ld_err    = 1'b1;
                  w_state_nxt = FLUSH;
               end
            end
            FLUSH: begin
               if (w_is_term) begin
                  w_state_nxt = IDLE;
               end
            end
            default: begin
               w_state_nxt = IDLE;
            end
         endcase
      end else if (w_timeout) begin
         w_state_nxt = IDLE;
         if (r_state != FLUSH) begin
            w_ld_err   = 1'b1;
            w_err_code = c_ERR_TMO;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (rx_valid || (r_state == IDLE)) begin
            r_cnt <= '0;
         end else if (r_cnt != c_TIMEOUT) begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_is_write <= 1'b0;
         r_nib_ahi  <= 4'h0;
         r_nib_alo  <= 4'h0;
         r_nib_dhi  <= 4'h0;
         r_nib_dlo  <= 4'h0;
      end else begin
         if (w_ld_op) begin
            r_is_write <= w_is_wr;
         end
         if (w_ld_nib) begin
            case (r_state)
               ADDR_HI: r_nib_ahi <= w_hex_val;
               ADDR_LO: r_nib_alo <= w_hex_val;
               DATA_HI: r_nib_dhi <= w_hex_val;
               default: r_nib_dlo <= w_hex_val;
            endcase
         end
      end
   end

   // Command fields change only with a completed frame, never on partial input.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cmd_valid <= 1'b0;
         r_cmd_write <= 1'b0;
         r_cmd_addr  <= 8'h00;
         r_cmd_wdata <= 8'h00;
         r_cmd_err   <= 1'b0;
         r_err_code  <= 2'b00;
      end else begin
         r_cmd_valid <= w_ld_valid;
         r_cmd_err   <= w_ld_err;
         if (w_ld_err) begin
            r_err_code <= w_err_code;
         end
         if (w_ld_valid) begin
            r_cmd_write <= r_is_write;
            r_cmd_addr  <= {r_nib_ahi, r_nib_alo};
            r_cmd_wdata <= r_is_write ? {r_nib_dhi, r_nib_dlo} : 8'h00;
         end
      end
   end

   assign cmd_valid = r_cmd_valid;
   assign cmd_write = r_cmd_write;
   assign cmd_addr  = r_cmd_addr;
   assign cmd_wdata = r_cmd_wdata;
   assign cmd_err   = r_cmd_err;
   assign err_code  = r_err_code;
   assign busy      = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_parser.sv
`default_nettype none
// ==========================================================================
// tb_uart_cmd_parser : directed self-checking bench for uart_cmd_parser
// Revision 1.0
// ==========================================================================
module tb_uart_cmd_parser;

   localparam int c_T = 20;

   logic       clk;
   logic       rst;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       cmd_valid;
   logic       cmd_write;
   logic [7:0] cmd_addr;
   logic [7:0] cmd_wdata;
   logic       cmd_err;
   logic [1:0] err_code;
   logic       busy;

   int checks   = 0;
   int failures = 0;
   int n_valid  = 0;
   int n_err    = 0;
   bit both_seen = 1'b0;

   uart_cmd_parser #(.TIMEOUT_CYCLES(c_T)) dut (
      .clk       (clk),
      .rst       (rst),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .cmd_valid (cmd_valid),
      .cmd_write (cmd_write),
      .cmd_addr  (cmd_addr),
      .cmd_wdata (cmd_wdata),
      .cmd_err   (cmd_err),
      .err_code  (err_code),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Strobes last one clock, so each negedge sees a given cycle exactly once.
   always @(negedge clk) begin
      if (cmd_valid === 1'b1) n_valid++;
      if (cmd_err === 1'b1) n_err++;
      if ((cmd_valid === 1'b1) && (cmd_err === 1'b1)) both_seen = 1'b1;
   end

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      #1;
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send_byte(s[i]);
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      wait_cycles(3);
      checks++; if (cmd_valid !== 1'b0) begin failures++; $display("FAIL rst_valid actual=%b required=0", cmd_valid); end
      checks++; if (cmd_write !== 1'b0) begin failures++; $display("FAIL rst_write actual=%b required=0", cmd_write); end
      checks++; if (cmd_addr !== 8'h00) begin failures++; $display("FAIL rst_addr actual=%h required=00", cmd_addr); end
      checks++; if (cmd_wdata !== 8'h00) begin failures++; $display("FAIL rst_wdata actual=%h required=00", cmd_wdata); end
      checks++; if (cmd_err !== 1'b0) begin failures++; $display("FAIL rst_err actual=%b required=0", cmd_err); end
      checks++; if (err_code !== 2'b00) begin failures++; $display("FAIL rst_code actual=%b required=00", err_code); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy actual=%b required=0", busy); end
      @(negedge clk);
      rst = 1'b0;
      wait_cycles(2);
   endtask

   task automatic test_write;
      send_str("W3Fa5");
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL wr_busy_mid actual=%b required=1", busy); end
      checks++; if (n_valid !== 0) begin failures++; $display("FAIL wr_early_valid actual=%0d required=0", n_valid); end
      send_byte(8'h0D);
      checks++; if (cmd_valid !== 1'b1) begin failures++; $display("FAIL wr_valid actual=%b required=1", cmd_valid); end
      checks++; if (cmd_write !== 1'b1) begin failures++; $display("FAIL wr_write actual=%b required=1", cmd_write); end
      checks++; if (cmd_addr !== 8'h3F) begin failures++; $display("FAIL wr_addr actual=%h required=3f", cmd_addr); end
      checks++; if (cmd_wdata !== 8'hA5) begin failures++; $display("FAIL wr_wdata actual=%h required=a5", cmd_wdata); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL wr_busy_after actual=%b required=0", busy); end
      wait_cycles(2);
      checks++; if (cmd_valid !== 1'b0) begin failures++; $display("FAIL wr_valid_width actual=%b required=0", cmd_valid); end
      checks++; if (n_valid !== 1) begin failures++; $display("FAIL wr_valid_count actual=%0d required=1", n_valid); end
      checks++; if (n_err !== 0) begin failures++; $display("FAIL wr_err_count actual=%0d required=0", n_err); end
   endtask

   task automatic test_read;
      send_str("r1c\n");
      checks++; if (cmd_valid !== 1'b1) begin failures++; $display("FAIL rd_valid actual=%b required=1", cmd_valid); end
      checks++; if (cmd_write !== 1'b0) begin failures++; $display("FAIL rd_write actual=%b required=0", cmd_write); end
      checks++; if (cmd_addr !== 8'h1C) begin failures++; $display("FAIL rd_addr actual=%h required=1c", cmd_addr); end
      checks++; if (cmd_wdata !== 8'h00) begin failures++; $display("FAIL rd_wdata actual=%h required=00", cmd_wdata); end
      wait_cycles(1);
   endtask

   task automatic test_bad_char;
      int e0 = n_err;
      int v0 = n_valid;
      send_str("W1G");
      checks++; if (cmd_err !== 1'b1) begin failures++; $display("FAIL bad_err actual=%b required=1", cmd_err); end
      checks++; if (err_code !== 2'b01) begin failures++; $display("FAIL bad_code actual=%b required=01", err_code); end
      send_str("77");
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL bad_flush_busy actual=%b required=1", busy); end
      checks++; if ({cmd_write, cmd_addr, cmd_wdata} !== {1'b0, 8'h1C, 8'h00}) begin failures++; $display("FAIL bad_hold actual=%b/%h/%h required=0/1c/00", cmd_write, cmd_addr, cmd_wdata); end
      send_byte(8'h0D);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL bad_flush_exit actual=%b required=0", busy); end
      send_str("R20\r");
      checks++; if (cmd_valid !== 1'b1 || cmd_addr !== 8'h20 || cmd_write !== 1'b0) begin failures++; $display("FAIL bad_next_cmd actual=%b/%h/%b required=1/20/0", cmd_valid, cmd_addr, cmd_write); end
      wait_cycles(1);
      checks++; if (n_err - e0 !== 1) begin failures++; $display("FAIL bad_err_count actual=%0d required=1", n_err - e0); end
      checks++; if (n_valid - v0 !== 1) begin failures++; $display("FAIL bad_valid_count actual=%0d required=1", n_valid - v0); end
   endtask

   task automatic test_timeout;
      int e0;
      send_str("W12");
      wait_cycles(c_T);
      checks++; if (cmd_err !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL tmo_early actual=%b/%b required=0/1", cmd_err, busy); end
      wait_cycles(1);
      checks++; if (cmd_err !== 1'b1) begin failures++; $display("FAIL tmo_err actual=%b required=1", cmd_err); end
      checks++; if (err_code !== 2'b10) begin failures++; $display("FAIL tmo_code actual=%b required=10", err_code); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL tmo_busy actual=%b required=0", busy); end
      wait_cycles(2);
      e0 = n_err;
      send_str("W12");
      wait_cycles(c_T - 1);
      send_byte("3");
      checks++; if (cmd_err !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL tmo_suppress actual=%b/%b required=0/1", cmd_err, busy); end
      send_str("4\r");
      checks++; if (cmd_valid !== 1'b1 || cmd_addr !== 8'h12 || cmd_wdata !== 8'h34) begin failures++; $display("FAIL tmo_after_cmd actual=%b/%h/%h required=1/12/34", cmd_valid, cmd_addr, cmd_wdata); end
      checks++; if (err_code !== 2'b10) begin failures++; $display("FAIL tmo_code_hold actual=%b required=10", err_code); end
      wait_cycles(1);
      checks++; if (n_err !== e0) begin failures++; $display("FAIL tmo_suppress_count actual=%0d required=%0d", n_err, e0); end
   endtask

   task automatic test_early_term;
      int e0 = n_err;
      send_str("R1\r");
      checks++; if (cmd_err !== 1'b1 || err_code !== 2'b01) begin failures++; $display("FAIL early_err actual=%b/%b required=1/01", cmd_err, err_code); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL early_idle actual=%b required=0", busy); end
      send_str("R12X");
      checks++; if (cmd_err !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL eol_bad actual=%b/%b required=1/1", cmd_err, busy); end
      send_byte(8'h0A);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL eol_flush_exit actual=%b required=0", busy); end
      wait_cycles(1);
      checks++; if (n_err - e0 !== 2) begin failures++; $display("FAIL early_err_count actual=%0d required=2", n_err - e0); end
   endtask

   task automatic test_blank;
      int e0 = n_err;
      send_str("\r\n ");
      checks++; if (busy !== 1'b0 || n_err !== e0) begin failures++; $display("FAIL blank_ignored actual=%b/%0d required=0/%0d", busy, n_err, e0); end
      send_byte("X");
      checks++; if (cmd_err !== 1'b1 || err_code !== 2'b01 || busy !== 1'b1) begin failures++; $display("FAIL blank_x actual=%b/%b/%b required=1/01/1", cmd_err, err_code, busy); end
      send_byte(8'h0D);
      wait_cycles(1);
      checks++; if (busy !== 1'b0 || n_err - e0 !== 1) begin failures++; $display("FAIL blank_end actual=%b/%0d required=0/1", busy, n_err - e0); end
   endtask

   task automatic test_reset_midframe;
      int e0 = n_err;
      int v0 = n_valid;
      send_str("W5");
      @(negedge clk);
      rst = 1'b1;
      #1;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_rst_async actual=%b required=0", busy); end
      checks++; if (cmd_addr !== 8'h00 || err_code !== 2'b00) begin failures++; $display("FAIL mid_rst_clear actual=%h/%b required=00/00", cmd_addr, err_code); end
      @(negedge clk);
      rst = 1'b0;
      wait_cycles(1);
      send_str("R0A\r");
      checks++; if (cmd_valid !== 1'b1 || cmd_addr !== 8'h0A || cmd_write !== 1'b0) begin failures++; $display("FAIL mid_rst_cmd actual=%b/%h/%b required=1/0a/0", cmd_valid, cmd_addr, cmd_write); end
      wait_cycles(1);
      checks++; if (n_err !== e0 || n_valid - v0 !== 1) begin failures++; $display("FAIL mid_rst_counts actual=%0d/%0d required=%0d/1", n_err, n_valid - v0, e0); end
   endtask

   task automatic test_back_to_back;
      send_str("R55\r");
      checks++; if (cmd_valid !== 1'b1 || cmd_addr !== 8'h55 || cmd_wdata !== 8'h00) begin failures++; $display("FAIL b2b_rd actual=%b/%h/%h required=1/55/00", cmd_valid, cmd_addr, cmd_wdata); end
      send_str("w6677\n");
      checks++; if (cmd_valid !== 1'b1 || cmd_write !== 1'b1 || cmd_addr !== 8'h66 || cmd_wdata !== 8'h77) begin failures++; $display("FAIL b2b_wr actual=%b/%b/%h/%h required=1/1/66/77", cmd_valid, cmd_write, cmd_addr, cmd_wdata); end
      wait_cycles(1);
      checks++; if (both_seen !== 1'b0) begin failures++; $display("FAIL strobe_exclusive actual=%b required=0", both_seen); end
   endtask

   initial begin
      rst      = 1'b1;
      rx_data  = 8'h00;
      rx_valid = 1'b0;
      test_reset();
      test_write();
      test_read();
      test_bad_char();
      test_timeout();
      test_early_term();
      test_blank();
      test_reset_midframe();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
